// File: rtl/mix_pkg.sv
// Shared types and default widths for the mixer normalizer back end.
package mix_pkg;
  localparam int SUM_W = 12;
  localparam int CNT_W = 4;
  localparam int OUT_W = 8;

  localparam logic [7:0] SILENCE = 8'h80;

  typedef enum logic [1:0] {IDLE, DIV, DONE} mix_state_t;
endpackage

// File: rtl/mix_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module mix_div_step
  import mix_pkg::*;
#(
  parameter int CNT_W = mix_pkg::CNT_W
) (
  input  logic [CNT_W-1:0] rem,
  input  logic [CNT_W-1:0] divisor,
  input  logic             din,
  output logic [CNT_W-1:0] rem_nx,
  output logic             q
);
  logic [CNT_W:0] sh;

  always_comb begin
    sh     = {rem, din};
    q      = (sh >= {1'b0, divisor});
    // remainder stays below the divisor, so the top bit is always zero here
    rem_nx = CNT_W'(q ? (sh - {1'b0, divisor}) : sh);
  end
endmodule

// File: rtl/mix_normalizer.sv
// Divides the mixed sum by the enabled-channel count with an iterative restoring
// divider. Define MIX_ROUND_EN for round-half-up instead of truncation.
module mix_normalizer
  import mix_pkg::*;
#(
  parameter int SUM_W = mix_pkg::SUM_W,
  parameter int CNT_W = mix_pkg::CNT_W,
  parameter int OUT_W = mix_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum_in,
  input  logic [CNT_W-1:0] num_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] sample_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
`ifdef MIX_ROUND_EN
  localparam int ITER = SUM_W + 1;
`else
  localparam int ITER = SUM_W;
`endif
  localparam int CW = $clog2(ITER);

  mix_state_t state, state_nx;

  logic [ITER-1:0]  dvd, dvd_in, quo, quo_nx;
  logic [CNT_W-1:0] dvs, rem, rem_nx;
  logic [CW-1:0]    cnt;
  logic             q_bit, zero, last;
  logic [OUT_W-1:0] sat;

  always_comb begin
`ifdef MIX_ROUND_EN
    dvd_in = ITER'(sum_in) + ITER'(num_in >> 1);
`else
    dvd_in = ITER'(sum_in);
`endif
  end

  mix_div_step #(.CNT_W(CNT_W)) u_step (
    .rem    (rem),
    .divisor(dvs),
    .din    (dvd[ITER-1]),
    .rem_nx (rem_nx),
    .q      (q_bit)
  );

  always_comb begin
    quo_nx = {quo[ITER-2:0], q_bit};
    last   = (cnt == CW'(ITER - 1));
    sat    = (quo_nx > ITER'((1 << OUT_W) - 1)) ? '1 : quo_nx[OUT_W-1:0];
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A zero count takes a single DIV pass (counter preset to the last step) so the
  // silence value is loaded on DONE entry, one edge after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      zero       <= 1'b0;
      sample_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          dvd  <= dvd_in;
          dvs  <= num_in;
          rem  <= '0;
          quo  <= '0;
          zero <= (num_in == '0);
          cnt  <= (num_in == '0) ? CW'(ITER - 1) : '0;
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) sample_out <= zero ? OUT_W'(SILENCE) : sat;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_normalizer.sv
// Randomized self-checking bench for mix_normalizer against an arithmetic model.
module tb_mix_normalizer;
`ifdef MIX_ROUND_EN
  localparam int ITER  = 13;
  localparam bit ROUND = 1'b1;
`else
  localparam int ITER  = 12;
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sum_in = '0;
  logic [3:0]  num_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  sample_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mix_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .num_in    (num_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample_out(sample_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int s, input int n);
    int q;
    if (n == 0) return 128;
    q = (s + (ROUND ? n / 2 : 0)) / n;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic do_op(input int s, input int n, input int hold);
    int edges;
    int exp;
    int lat;
    exp = model(s, n);
    lat = (n == 0) ? 1 : ITER;
    @(negedge clk);
    sum_in    = 12'(s);
    num_in    = 4'(n);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (n != 0) check("busy_div", busy, 1);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, lat);
    check("sample", sample_out, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      sum_in   = 12'($urandom);
      num_in   = 4'($urandom);
      @(posedge clk); #1;
      check("bp_stable", sample_out, exp);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sample", sample_out, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    do_op(600, 3, 0);
    do_op(123, 0, 0);
    do_op(3060, 1, 1);
    do_op(10, 4, 0);
    do_op(4095, 15, 2);
    do_op(0, 7, 0);
    do_op(1000, 6, 5);

    // Reset in the fifth DIV cycle discards the operation.
    @(negedge clk);
    sum_in   = 12'd600;
    num_in   = 4'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sample", sample_out, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    do_op(48, 4, 2);

    for (int k = 0; k < 40; k++) begin
      int s;
      int n;
      s = int'($urandom_range(0, 4095));
      n = (k % 8 == 0) ? 1 : int'($urandom_range(0, 15));
      do_op(s, n, int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mix_normalizer.md
# mix_normalizer

Sequential back end for the signal mixer. Takes the 12-bit sum of enabled samples and the 4-bit count of enabled channels, then divides the sum by the count with an iterative restoring divider. The result is one 8-bit averaged sample per request, delivered to the PWM/DAC output stage. Valid/ready handshakes are used on both sides, so the mixer's combinational output is captured once per audio sample tick.

## Interface
- SUM_W, 12, width of mixed sum input
- CNT_W, 4, width of enabled-channel count
- OUT_W, 8, width of normalized output sample
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- sum_in  input  SUM_W  unsigned sum of enabled samples
- num_in  input  CNT_W  number of enabled channels (0..12 nominal)
- in_valid  input  1  sum_in/num_in valid this cycle
- in_ready  output  1  block can accept an operand pair
- sample_out  output  OUT_W  normalized sample
- out_valid  output  1  sample_out valid
- out_ready  input  1  downstream accepts sample_out
- busy  output  1  division in progress (state DIV)

## Operation
- FSM states: IDLE, DIV, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready, latch both operands.
  - num_in==0: load sample_out=SILENCE (8'h80), go to DONE.
  - Otherwise: go to DIV with remainder=0 and iteration counter=0.
- DIV: each cycle performs one restoring step:
  - remainder = {remainder, next dividend MSB};
  - if remainder >= divisor, subtract and shift in quotient bit 1; otherwise shift in 0.
  - After ITER steps, go to DONE.
  - ITER = SUM_W, or SUM_W+1 with rounding (see Configuration).
- Quotient register is ITER bits wide, with no truncation before saturation.
  - On entering DONE, sample_out = quotient > 255 ? 8'hFF : quotient[7:0].
  - Saturation only occurs when num_in understates the true channel count, e.g. num_in=1.
- DONE: out_valid=1; sample_out held stable. On out_ready, go to IDLE.
- in_ready=0 in DIV and DONE. in_valid is ignored there; operands are never re-latched mid-operation.
- Reset (async, any state): state=IDLE; sample_out=0; out_valid=0; busy=0; in_ready=1 once rst deasserts. The iteration counter and remainder are cleared. Any in-flight division is discarded with no output.

## Timing
- Accepting edge k (in_valid && in_ready).
  - For num_in!=0, out_valid rises after edge k+ITER: 12 edges, or 13 with rounding.
  - For num_in==0, out_valid rises after edge k+1.
- Output handshake on edge m (out_valid && out_ready): out_valid falls and in_ready rises after edge m.
- Minimum period between accepts is ITER+2 cycles, which is ample versus the audio sample rate.
- out_ready may be held high; DONE then lasts exactly one cycle.
- sample_out changes only on entry to DONE or on reset.

## Configuration
- MIX_ROUND_EN defined (round to nearest, half up):
  - dividend = sum_in + (num_in >> 1), computed at SUM_W+1 bits;
  - ITER = SUM_W+1.
- MIX_ROUND_EN undefined (truncate):
  - dividend = sum_in;
  - ITER = SUM_W.
- The num_in==0 path is unaffected by MIX_ROUND_EN.

## Structure
- Package mix_pkg holds:
  - state enum mix_state_t {IDLE, DIV, DONE};
  - SUM_W/CNT_W/OUT_W default localparams;
  - SILENCE = 8'h80.
- Sub-module mix_div_step: one combinational restoring step.
  - Inputs: remainder, divisor, incoming bit.
  - Outputs: next remainder, quotient bit.
  - The top instantiates one copy and iterates it.
- Top holds the FSM, operand and quotient registers, the counter, and the saturation logic.

## Test plan
- Basic divide: sum_in=600, num_in=3 -> sample_out=200; out_valid 12 edges after accept (13 with MIX_ROUND_EN).
- Zero channels: num_in=0, sum_in=123 -> sample_out=8'h80; out_valid after 1 edge.
- Saturation: sum_in=3060, num_in=1 -> sample_out=8'hFF.
- Rounding: sum_in=10, num_in=4 -> 2 without MIX_ROUND_EN, 3 with it.
- Backpressure: out_ready low for 5 cycles in DONE, with in_valid pulsed and new operands presented.
  - Required: sample_out stable, in_ready=0, new operands not latched.
  - After out_ready=1: IDLE next cycle.
- Reset mid-op: assert rst at the 5th DIV cycle.
  - Required: immediately out_valid=0, sample_out=0, busy=0; in_ready=1 after release.
  - A new request sum_in=48, num_in=4 then yields 12.
